// File: rtl/sccb_slave.sv
// sccb_slave: SCCB register-access slave, oversampled on clk_i.
// Write: DEV(W) / addr hi / addr lo / data... ; Read: DEV(R) / data... with
// master ACK per byte. The optional read path is enabled by defining
// SCCB_SLAVE_READ_EN; without it, read device bytes are NACKed.
// Register-side handshake: reg_we_o and reg_re_o are single-cycle strobes
// with no back-pressure; reg_addr_o/reg_wdata_o are valid while reg_we_o is
// high, and reg_rdata_i is sampled one clk_i after the cycle reg_re_o is high.
// state_o exposes the FSM state for debug and checkers.
module sccb_slave #(
  parameter logic [7:0] DEV_ID = 8'h78
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sioc_i,
  inout  wire         siod_io,
  output logic [15:0] reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  input  logic [7:0]  reg_rdata_i,
  output logic        busy_o,
  output logic [3:0]  state_o
);

`ifdef SCCB_SLAVE_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WD, WD_ACK, RD, RD_ACK, WAIT_STOP
  } state_t;

  state_t      state;
  logic        sioc_s1, sioc_s2, sioc_q;
  logic        siod_s1, siod_s2, siod_q;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        oe;        // 1 = pull SIOD low
  logic        rw;        // device byte bit 0
  logic        rd_ack;    // master ACKed the last read byte
  logic        we_pend;
  logic        re;
  logic        re_q;

  logic        sioc_rise, sioc_fall, start, stop;
  logic [7:0]  byte_in;

  assign siod_io = oe ? 1'b0 : 1'bz;
  assign state_o = state;

`ifdef SCCB_SLAVE_READ_EN
  assign reg_re_o = re;
`else
  assign reg_re_o = 1'b0;
`endif

  // Edge and bus-condition detection on synchronized line values
  always_comb begin
    sioc_rise = sioc_s2 & ~sioc_q;
    sioc_fall = ~sioc_s2 & sioc_q;
    start     = sioc_s2 & sioc_q & siod_q & ~siod_s2;
    stop      = sioc_s2 & sioc_q & ~siod_q & siod_s2;
    byte_in   = {shreg[6:0], siod_s2};
  end

  // Two-flop synchronizers plus one history stage for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sioc_s1 <= 1'b1; sioc_s2 <= 1'b1; sioc_q <= 1'b1;
      siod_s1 <= 1'b1; siod_s2 <= 1'b1; siod_q <= 1'b1;
    end else begin
      sioc_s1 <= sioc_i;  sioc_s2 <= sioc_s1; sioc_q <= sioc_s2;
      siod_s1 <= siod_io; siod_s2 <= siod_s1; siod_q <= siod_s2;
    end
  end

  // Protocol FSM with registered outputs and strobe pipeline
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'd0;
      oe          <= 1'b0;
      rw          <= 1'b0;
      rd_ack      <= 1'b0;
      we_pend     <= 1'b0;
      re          <= 1'b0;
      re_q        <= 1'b0;
      reg_addr_o  <= 16'd0;
      reg_wdata_o <= 8'd0;
      reg_we_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      // Strobe pipeline: write strobe one cycle after the byte lands, address
      // bump one cycle after the strobe; read data captured one cycle after re.
      we_pend  <= 1'b0;
      reg_we_o <= we_pend;
      re       <= 1'b0;
      re_q     <= re;
      if (reg_we_o) reg_addr_o <= reg_addr_o + 16'd1;
      if (re_q)     shreg      <= reg_rdata_i;

      if (start) begin
        state   <= DEV;
        bit_cnt <= 4'd0;
        oe      <= 1'b0;
        rd_ack  <= 1'b0;
        busy_o  <= 1'b1;
      end else if (stop) begin
        state   <= IDLE;
        oe      <= 1'b0;
        rd_ack  <= 1'b0;
        busy_o  <= 1'b0;
      end else begin
        case (state)
          DEV, AH, AL, WD: begin
            if (sioc_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                case (state)
                  DEV: begin
                    if (byte_in[7:1] != DEV_ID[7:1] || (byte_in[0] && !READ_EN)) begin
                      state <= WAIT_STOP;
                    end else begin
                      rw    <= byte_in[0];
                      state <= DEV_ACK;
                    end
                  end
                  AH: begin
                    reg_addr_o[15:8] <= byte_in;
                    state            <= AH_ACK;
                  end
                  AL: begin
                    reg_addr_o[7:0] <= byte_in;
                    state           <= AL_ACK;
                  end
                  default: begin
                    reg_wdata_o <= byte_in;
                    we_pend     <= 1'b1;
                    state       <= WD_ACK;
                  end
                endcase
              end
            end
          end
          DEV_ACK, AH_ACK, AL_ACK, WD_ACK: begin
            // First falling edge starts the ACK, the second one ends it.
            if (sioc_fall) begin
              if (!oe) begin
                oe <= 1'b1;
                if (state == DEV_ACK && rw) re <= 1'b1;
              end else begin
                oe      <= 1'b0;
                bit_cnt <= 4'd0;
                case (state)
                  DEV_ACK: begin
                    if (rw) begin
                      oe    <= ~shreg[7];
                      shreg <= {shreg[6:0], 1'b0};
                      state <= RD;
                    end else begin
                      state <= AH;
                    end
                  end
                  AH_ACK:  state <= AL;
                  default: state <= WD;
                endcase
              end
            end
          end
          RD: begin
            if (sioc_rise) bit_cnt <= bit_cnt + 4'd1;
            if (sioc_fall) begin
              if (bit_cnt == 4'd8) begin
                oe    <= 1'b0;
                state <= RD_ACK;
              end else begin
                oe    <= ~shreg[7];
                shreg <= {shreg[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (sioc_rise) begin
              if (!siod_s2) begin
                reg_addr_o <= reg_addr_o + 16'd1;
                re         <= 1'b1;
                rd_ack     <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end
            if (sioc_fall && rd_ack) begin
              rd_ack  <= 1'b0;
              oe      <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= 4'd0;
              state   <= RD;
            end
          end
          default: ;  // IDLE and WAIT_STOP wait for START/STOP only
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: bit-banged SCCB master driving sccb_slave, with a scoreboard
// of expected register strobes built from transaction-level rules.
module tb_sccb_slave;
  localparam int T = 16;  // SIOC half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sioc = 1'b1;
  logic        m_low = 1'b0;
  wire         siod;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic [3:0]  dbg_state;

  pullup (siod);
  assign siod = m_low ? 1'b0 : 1'bz;

  // clock
  always #5 clk = ~clk;

  sccb_slave dut (
    .clk_i(clk), .rst_i(rst), .sioc_i(sioc), .siod_io(siod),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_we_o(reg_we),
    .reg_re_o(reg_re), .reg_rdata_i(reg_rdata), .busy_o(busy), .state_o(dbg_state)
  );

  // register file read model
  function automatic logic [7:0] ref_rdata(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 16'h3017) ? 8'hA5 : (lo ^ 8'h3C);
  endfunction
  always_comb reg_rdata = ref_rdata(reg_addr);

  int          n_checks = 0;
  int          n_fail = 0;
  int          re_total = 0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [15:0] obs_re_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (reg_we) obs_q.push_back({reg_addr, reg_wdata});
      if (reg_re) begin
        obs_re_q.push_back(reg_addr);
        re_total++;
      end
    end
  end

  // watchdog
  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    m_low = 1'b0; wait_clk(T);
    sioc = 1'b1;  wait_clk(T);
    m_low = 1'b1; wait_clk(T);
    sioc = 1'b0;  wait_clk(T);
  endtask

  task automatic m_stop();
    sioc = 1'b0; m_low = 1'b1; wait_clk(T);
    sioc = 1'b1; wait_clk(T);
    m_low = 1'b0; wait_clk(T);
  endtask

  task automatic m_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_low = ~b[i]; wait_clk(T);
      sioc = 1'b1;   wait_clk(T);
      sioc = 1'b0;   wait_clk(2);
    end
  endtask

  task automatic m_byte(input logic [7:0] b, output logic ack);
    m_bits(b, 8);
    m_low = 1'b0; wait_clk(T);
    sioc = 1'b1;  wait_clk(T / 2);
    ack = siod;   wait_clk(T / 2);
    sioc = 1'b0;  wait_clk(2);
  endtask

  task automatic m_read(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; wait_clk(T);
      sioc = 1'b1;  wait_clk(T / 2);
      d[i] = siod;  wait_clk(T / 2);
      sioc = 1'b0;  wait_clk(2);
    end
    m_low = ~nack; wait_clk(T);
    sioc = 1'b1;   wait_clk(T);
    sioc = 1'b0;   wait_clk(2);
    m_low = 1'b0;
  endtask

  // compare observed write strobes against the expected queue
  task automatic sb_check(input string tag);
    logic [23:0] e, o;
    check_eq({tag, "_strobe_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq({tag, "_strobe"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // full write transaction: address phase plus n data bytes, then STOP
  task automatic do_write(input string tag, input logic [15:0] a, input int n,
                          input logic [7:0] d [4]);
    logic        ack;
    logic [15:0] ptr;
    ptr = a;
    m_start();
    check_eq({tag, "_busy"}, busy, 1'b1);
    m_byte(8'h78, ack);   check_eq({tag, "_ack_dev"}, ack, 1'b0);
    m_byte(a[15:8], ack); check_eq({tag, "_ack_ah"}, ack, 1'b0);
    m_byte(a[7:0], ack);  check_eq({tag, "_ack_al"}, ack, 1'b0);
    for (int i = 0; i < n; i++) begin
      m_byte(d[i], ack);
      check_eq({tag, "_ack_wd"}, ack, 1'b0);
      exp_q.push_back({ptr, d[i]});
      ptr = ptr + 16'd1;
    end
    m_stop();
    wait_clk(4);
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_addr"}, reg_addr, ptr);
    if (n > 0) check_eq({tag, "_wdata"}, reg_wdata, d[n - 1]);
    sb_check(tag);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d0, d1;
    logic [7:0] rd [4];
    logic [15:0] ra;
    int          rn;

    // reset
    wait_clk(10);
    check_eq("rst_addr", reg_addr, 16'h0000);
    check_eq("rst_wdata", reg_wdata, 8'h00);
    check_eq("rst_we", reg_we, 1'b0);
    check_eq("rst_re", reg_re, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_siod", siod, 1'b1);
    rst = 1'b1;
    wait_clk(10);

    // 3-phase write 78/30/17/5A
    do_write("w3017", 16'h3017, 1, '{8'h5A, 8'h00, 8'h00, 8'h00});

    // 2-phase write sets the pointer only
    do_write("w2ph", 16'h1234, 0, '{8'h00, 8'h00, 8'h00, 8'h00});

    // burst write across the address wrap
    do_write("wwrap", 16'hFFFF, 2, '{8'h11, 8'h22, 8'h00, 8'h00});

    // foreign device ID is ignored
    m_start();
    m_byte(8'h42, ack); check_eq("bad_id_nack", ack, 1'b1);
    m_byte(8'h30, ack); check_eq("bad_id_ignored", ack, 1'b1);
    m_stop();
    wait_clk(4);
    check_eq("bad_id_idle", busy, 1'b0);
    check_eq("bad_id_addr", reg_addr, 16'h0001);
    sb_check("bad_id");

    // STOP mid-byte aborts without a strobe
    m_start();
    m_byte(8'h78, ack);
    m_byte(8'h55, ack);
    m_byte(8'h66, ack);
    m_bits(8'hAA, 4);
    m_stop();
    wait_clk(4);
    check_eq("abort_stop_addr", reg_addr, 16'h5566);
    check_eq("abort_stop_idle", busy, 1'b0);
    sb_check("abort_stop");

    // repeated START mid-byte aborts, new transaction proceeds
    m_start();
    m_byte(8'h78, ack);
    m_byte(8'h01, ack);
    m_byte(8'h02, ack);
    m_bits(8'hC3, 3);
    do_write("rstart", 16'h0A0B, 1, '{8'h77, 8'h00, 8'h00, 8'h00});

    // randomized writes
    for (int it = 0; it < 8; it++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      if (it == 3) ra = 16'hFFFE;
      rn = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) rd[k] = 8'($urandom_range(0, 255));
      do_write("wrand", ra, rn, rd);
    end

    // read path
    do_write("rd_setup", 16'h3017, 0, '{8'h00, 8'h00, 8'h00, 8'h00});
`ifdef SCCB_SLAVE_READ_EN
    m_start();
    m_byte(8'h79, ack); check_eq("rd_ack_dev", ack, 1'b0);
    m_read(d0, 1'b1);   check_eq("rd_data", d0, 8'hA5);
    m_stop();
    wait_clk(4);
    check_eq("rd_re_count", obs_re_q.size(), 1);
    if (obs_re_q.size() > 0) check_eq("rd_re_addr", obs_re_q.pop_front(), 16'h3017);
    obs_re_q.delete();
    check_eq("rd_addr_kept", reg_addr, 16'h3017);
    m_start();
    m_byte(8'h79, ack); check_eq("rdb_ack_dev", ack, 1'b0);
    m_read(d0, 1'b0);   check_eq("rdb_data0", d0, 8'hA5);
    m_read(d1, 1'b1);   check_eq("rdb_data1", d1, ref_rdata(16'h3018));
    m_stop();
    wait_clk(4);
    check_eq("rdb_re_count", obs_re_q.size(), 2);
    if (obs_re_q.size() > 1) begin
      check_eq("rdb_re_addr0", obs_re_q.pop_front(), 16'h3017);
      check_eq("rdb_re_addr1", obs_re_q.pop_front(), 16'h3018);
    end
    obs_re_q.delete();
    check_eq("rdb_addr", reg_addr, 16'h3018);
    check_eq("rdb_idle", busy, 1'b0);
`else
    m_start();
    m_byte(8'h79, ack); check_eq("rd_dis_nack", ack, 1'b1);
    m_stop();
    wait_clk(4);
    check_eq("rd_dis_idle", busy, 1'b0);
    check_eq("rd_dis_re_count", re_total, 0);
`endif
    sb_check("rd");

    // reset while the slave drives ACK
    m_start();
    m_bits(8'h78, 8);
    m_low = 1'b0;
    wait_clk(6);
    check_eq("rst_ack_driven", siod, 1'b0);
    rst = 1'b0;
    wait_clk(1);
    check_eq("rst_mid_siod", siod, 1'b1);
    check_eq("rst_mid_addr", reg_addr, 16'h0000);
    check_eq("rst_mid_wdata", reg_wdata, 8'h00);
    check_eq("rst_mid_we", reg_we, 1'b0);
    check_eq("rst_mid_re", reg_re, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    wait_clk(3);
    rst = 1'b1;
    sioc = 1'b1; wait_clk(T);
    sioc = 1'b0; wait_clk(T);
    check_eq("rst_stays_idle", busy, 1'b0);
    m_stop();
    do_write("post_rst", 16'h4242, 1, '{8'h99, 8'h00, 8'h00, 8'h00});

`ifndef SCCB_SLAVE_READ_EN
    check_eq("re_never", re_total, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
